// File: rtl/hazard_fwd_unit_if.sv
// Hazard/forwarding unit bus: pipeline-stage info in, resolved operands,
// stall and bypass selection out. Master = pipeline side, slave = unit.
interface hazard_fwd_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            ex_valid, ex_we, ex_is_load;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            mem_valid, mem_we;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            id_valid;
  logic [4:0]      id_rs1, id_rs2;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data;
  logic            stall;
  logic [XLEN-1:0] rs1_out, rs2_out;
  logic [3:0]      bypass_flag;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ex_valid, ex_we, ex_is_load, ex_rd, ex_result,
    output mem_valid, mem_we, mem_rd, mem_result,
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
    input  stall, rs1_out, rs2_out, bypass_flag, stall_count
  );

  modport slave (
    input  ex_valid, ex_we, ex_is_load, ex_rd, ex_result,
    input  mem_valid, mem_we, mem_rd, mem_result,
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
    output stall, rs1_out, rs2_out, bypass_flag, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use stall control for a 5-stage pipeline.
// All outputs are registered (one cycle after the inputs are sampled).
// Optional macro FWD_MEM_STAGE_EN enables forwarding from the MEM stage;
// without it the mem_* inputs are ignored and such matches use the regfile.
module hazard_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_unit_if.slave io_hif
);

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_lat_cnt, w_lat_cnt_nxt;
  logic            w_stall_nxt;
  logic            r_stall;
  logic [XLEN-1:0] r_rs1, r_rs2, w_rs1_nxt, w_rs2_nxt;
  logic [1:0]      w_sel1, w_sel2;
  logic [3:0]      r_flag;
  logic [CNT_W-1:0] r_stall_count;

  logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2, w_load_use;

  assign w_ex_hit1 = io_hif.ex_valid & io_hif.ex_we &
                     (io_hif.ex_rd == io_hif.id_rs1) & (io_hif.id_rs1 != 5'd0);
  assign w_ex_hit2 = io_hif.ex_valid & io_hif.ex_we &
                     (io_hif.ex_rd == io_hif.id_rs2) & (io_hif.id_rs2 != 5'd0);

`ifdef FWD_MEM_STAGE_EN
  assign w_mem_hit1 = io_hif.mem_valid & io_hif.mem_we &
                      (io_hif.mem_rd == io_hif.id_rs1) & (io_hif.id_rs1 != 5'd0);
  assign w_mem_hit2 = io_hif.mem_valid & io_hif.mem_we &
                      (io_hif.mem_rd == io_hif.id_rs2) & (io_hif.id_rs2 != 5'd0);
`else
  assign w_mem_hit1 = 1'b0;
  assign w_mem_hit2 = 1'b0;
  logic w_unused_mem;
  assign w_unused_mem = ^{io_hif.mem_valid, io_hif.mem_we, io_hif.mem_rd, io_hif.mem_result};
`endif

  // A load in EX cannot supply its data yet: it never forwards, it stalls.
  assign w_load_use = io_hif.id_valid & io_hif.ex_is_load & (w_ex_hit1 | w_ex_hit2);

  // Source select per port: EX (non-load) over MEM over regfile; invalid ID -> regfile.
  // A load match in EX falls through to the older stages; the stall replays it anyway.
  always_comb begin
    w_sel1 = 2'b00;
    w_sel2 = 2'b00;
    if (io_hif.id_valid) begin
      if (w_ex_hit1 & ~io_hif.ex_is_load) w_sel1 = 2'b01;
      else if (w_mem_hit1)                w_sel1 = 2'b10;
      if (w_ex_hit2 & ~io_hif.ex_is_load) w_sel2 = 2'b01;
      else if (w_mem_hit2)                w_sel2 = 2'b10;
    end
  end

  // Operand data mux driven by the source selects.
  always_comb begin
    w_rs1_nxt = io_hif.id_rs1_data;
    w_rs2_nxt = io_hif.id_rs2_data;
    case (w_sel1)
      2'b01:   w_rs1_nxt = io_hif.ex_result;
      2'b10:   w_rs1_nxt = io_hif.mem_result;
      default: w_rs1_nxt = io_hif.id_rs1_data;
    endcase
    case (w_sel2)
      2'b01:   w_rs2_nxt = io_hif.ex_result;
      2'b10:   w_rs2_nxt = io_hif.mem_result;
      default: w_rs2_nxt = io_hif.id_rs2_data;
    endcase
  end

  // FSM state and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  // Next state: hazards are only looked at in IDLE or on the last stall
  // cycle, so a back-to-back hazard reloads without a gap cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_load_use) begin
          w_state_nxt   = ST_STALL;
          w_lat_cnt_nxt = LAT;
        end
      end
      ST_STALL: begin
        if (r_lat_cnt <= 3'd1) begin
          if (w_load_use) begin
            w_lat_cnt_nxt = LAT;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_lat_cnt_nxt = 3'd0;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_lat_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Output decode: stall is asserted for every cycle spent in STALL.
  always_comb begin
    w_stall_nxt = (w_state_nxt == ST_STALL);
  end

  // Registered outputs and saturating stall performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall       <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_flag        <= 4'b0000;
      r_stall_count <= '0;
    end else begin
      r_stall <= w_stall_nxt;
      r_rs1   <= w_rs1_nxt;
      r_rs2   <= w_rs2_nxt;
      r_flag  <= {w_sel2, w_sel1};
      if (w_stall_nxt && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign io_hif.stall       = r_stall;
  assign io_hif.rs1_out     = r_rs1;
  assign io_hif.rs2_out     = r_rs2;
  assign io_hif.bypass_flag = r_flag;
  assign io_hif.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the forwarding/stall rules.
module tb_hazard_fwd_unit;
  localparam int XLEN = 32;
  localparam int LAT  = 3;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.XLEN(XLEN), .CNT_W(CW)) hif();
  hazard_fwd_unit #(.XLEN(XLEN), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .io_hif(hif)
  );

  int checks = 0;
  int errors = 0;

  // model state and expectations
  int              m_rem;
  int              m_cnt;
  logic            e_stall;
  logic [XLEN-1:0] e_rs1, e_rs2;
  logic [3:0]      e_flag;
  logic [CW-1:0]   e_cnt;

`ifdef FWD_MEM_STAGE_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  function automatic void resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] d, output logic [1:0] src);
    d = rf; src = 2'b00;
    if (hif.id_valid && rs != 0) begin
      if (hif.ex_valid && hif.ex_we && hif.ex_rd == rs && !hif.ex_is_load) begin
        d = hif.ex_result; src = 2'b01;
      end else if (MEM_EN && hif.mem_valid && hif.mem_we && hif.mem_rd == rs) begin
        d = hif.mem_result; src = 2'b10;
      end
    end
  endfunction

  function automatic void model_step();
    logic [1:0] s1, s2;
    logic [XLEN-1:0] d1, d2;
    bit hz;
    if (rst) begin
      m_rem = 0; m_cnt = 0;
      e_stall = 0; e_rs1 = '0; e_rs2 = '0; e_flag = '0; e_cnt = '0;
      return;
    end
    resolve(hif.id_rs1, hif.id_rs1_data, d1, s1);
    resolve(hif.id_rs2, hif.id_rs2_data, d2, s2);
    hz = hif.id_valid && hif.ex_valid && hif.ex_we && hif.ex_is_load &&
         ((hif.ex_rd == hif.id_rs1 && hif.id_rs1 != 0) ||
          (hif.ex_rd == hif.id_rs2 && hif.id_rs2 != 0));
    // remaining stall cycles; a new hazard is accepted once at most one remains
    if (m_rem <= 1 && hz) m_rem = LAT;
    else if (m_rem > 0)   m_rem = m_rem - 1;
    e_stall = (m_rem > 0);
    if (e_stall && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    e_cnt  = CW'(m_cnt);
    e_rs1  = d1; e_rs2 = d2; e_flag = {s2, s1};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    hif.ex_valid = 0; hif.ex_we = 0; hif.ex_is_load = 0; hif.ex_rd = 0; hif.ex_result = 0;
    hif.mem_valid = 0; hif.mem_we = 0; hif.mem_rd = 0; hif.mem_result = 0;
    hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_rs1_data = 0; hif.id_rs2_data = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); cycle(); rst = 0;
  endtask

  task automatic load_hazard(input logic [4:0] rd);
    hif.ex_valid = 1; hif.ex_we = 1; hif.ex_is_load = 1; hif.ex_rd = rd;
    hif.id_valid = 1; hif.id_rs1 = rd; hif.id_rs2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    hif.ex_valid = 1; hif.ex_we = 1; hif.ex_is_load = 0; hif.ex_rd = 3; hif.ex_result = 32'hDEAD;
    hif.id_valid = 1; hif.id_rs1 = 3; hif.id_rs2 = 3; hif.id_rs1_data = 32'h55; hif.id_rs2_data = 32'h66;
    cycle();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", hif.stall); end
    checks++; if (hif.rs1_out !== '0) begin errors++; $display("FAIL reset_rs1 got %h want 0", hif.rs1_out); end
    checks++; if (hif.rs2_out !== '0) begin errors++; $display("FAIL reset_rs2 got %h want 0", hif.rs2_out); end
    checks++; if (hif.bypass_flag !== 4'b0000) begin errors++; $display("FAIL reset_flag got %b want 0000", hif.bypass_flag); end
    checks++; if (hif.stall_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", hif.stall_count); end
    rst = 0; idle_inputs();
  endtask

  task automatic test_ex_fwd();
    idle_inputs();
    hif.ex_valid = 1; hif.ex_we = 1; hif.ex_rd = 5; hif.ex_result = 32'h1234;
    hif.id_valid = 1; hif.id_rs1 = 5; hif.id_rs1_data = 32'h9999; hif.id_rs2 = 6; hif.id_rs2_data = 32'h7777;
    cycle();
    checks++; if (hif.rs1_out !== 32'h1234) begin errors++; $display("FAIL ex_fwd_rs1 got %h want 1234", hif.rs1_out); end
    checks++; if (hif.bypass_flag !== 4'b0001) begin errors++; $display("FAIL ex_fwd_flag got %b want 0001", hif.bypass_flag); end
    checks++; if (hif.rs2_out !== 32'h7777) begin errors++; $display("FAIL ex_fwd_rs2 got %h want 7777", hif.rs2_out); end
  endtask

  task automatic test_priority();
    idle_inputs();
    hif.ex_valid = 1; hif.ex_we = 1; hif.ex_rd = 7; hif.ex_result = 32'hAA;
    hif.mem_valid = 1; hif.mem_we = 1; hif.mem_rd = 7; hif.mem_result = 32'hBB;
    hif.id_valid = 1; hif.id_rs2 = 7; hif.id_rs2_data = 32'hCC; hif.id_rs1 = 7; hif.id_rs1_data = 32'hCC;
    cycle();
    checks++; if (hif.rs2_out !== 32'hAA) begin errors++; $display("FAIL prio_ex_rs2 got %h want aa", hif.rs2_out); end
    checks++; if (hif.bypass_flag !== 4'b0101) begin errors++; $display("FAIL prio_ex_flag got %b want 0101", hif.bypass_flag); end
    hif.ex_valid = 0;
    cycle();
    checks++; if (hif.rs2_out !== (MEM_EN ? 32'hBB : 32'hCC)) begin errors++; $display("FAIL prio_mem_rs2 got %h want %h", hif.rs2_out, MEM_EN ? 32'hBB : 32'hCC); end
    checks++; if (hif.bypass_flag !== (MEM_EN ? 4'b1010 : 4'b0000)) begin errors++; $display("FAIL prio_mem_flag got %b want %b", hif.bypass_flag, MEM_EN ? 4'b1010 : 4'b0000); end
  endtask

  task automatic test_x0();
    idle_inputs();
    hif.ex_valid = 1; hif.ex_we = 1; hif.ex_rd = 0; hif.ex_result = 32'hFFFF;
    hif.mem_valid = 1; hif.mem_we = 1; hif.mem_rd = 0; hif.mem_result = 32'hEEEE;
    hif.id_valid = 1; hif.id_rs1 = 0; hif.id_rs1_data = 0;
    cycle();
    checks++; if (hif.rs1_out !== '0) begin errors++; $display("FAIL x0_rs1 got %h want 0", hif.rs1_out); end
    checks++; if (hif.bypass_flag !== 4'b0000) begin errors++; $display("FAIL x0_flag got %b want 0000", hif.bypass_flag); end
  endtask

  task automatic test_id_invalid();
    do_reset();
    load_hazard(5'd4);
    hif.id_valid = 0; hif.ex_is_load = 0; hif.id_rs1_data = 32'h42;
    cycle();
    checks++; if (hif.bypass_flag !== 4'b0000) begin errors++; $display("FAIL idinv_flag got %b want 0000", hif.bypass_flag); end
    checks++; if (hif.rs1_out !== 32'h42) begin errors++; $display("FAIL idinv_rs1 got %h want 42", hif.rs1_out); end
    hif.ex_is_load = 1;
    cycle();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL idinv_stall got %0b want 0", hif.stall); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    int hi;
    do_reset();
    load_hazard(5'd9);
    cycle();
    idle_inputs();
    hi = (hif.stall === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (hif.stall === 1'b1) hi++;
    end
    checks++; if (hi != LAT) begin errors++; $display("FAIL load_use_len got %0d want %0d", hi, LAT); end
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL load_use_end got %0b want 0", hif.stall); end
    checks++; if (hif.stall_count !== CW'(LAT)) begin errors++; $display("FAIL load_use_cnt got %0d want %0d", hif.stall_count, LAT); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    load_hazard(5'd9);
    cycle();
    idle_inputs();
    cycle();
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL mid_pre got %0b want 1", hif.stall); end
    rst = 1;
    cycle();
    rst = 0;
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0b want 0", hif.stall); end
    checks++; if (hif.stall_count !== '0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", hif.stall_count); end
    cycle();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL mid_after got %0b want 0", hif.stall); end
  endtask

  task automatic test_back_to_back();
    int hi;
    bit gap;
    do_reset();
    hi = 0; gap = 0;
    for (int i = 0; i < 2 * LAT + 3; i++) begin
      if (i == 0 || i == LAT) load_hazard(5'd11);
      else idle_inputs();
      cycle();
      if (hif.stall === 1'b1) begin
        hi++;
        if (i >= 2 * LAT) gap = 1;
      end else if (i < 2 * LAT) gap = 1;
    end
    checks++; if (hi != 2 * LAT || gap) begin errors++; $display("FAIL b2b_len got %0d gap %0b want %0d", hi, gap, 2 * LAT); end
    checks++; if (hif.stall_count !== CW'(2 * LAT)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", hif.stall_count, 2 * LAT); end
  endtask

  task automatic test_saturate();
    do_reset();
    load_hazard(5'd12);
    for (int i = 0; i < 30; i++) cycle();
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0b want 1", hif.stall); end
    checks++; if (hif.stall_count !== {CW{1'b1}}) begin errors++; $display("FAIL sat_cnt got %0d want %0d", hif.stall_count, (1 << CW) - 1); end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      hif.ex_valid = 1'($urandom); hif.ex_we = 1'($urandom);
      hif.ex_is_load = ($urandom_range(0, 3) == 0);
      hif.ex_rd = 5'($urandom_range(0, 3)); hif.ex_result = $urandom;
      hif.mem_valid = 1'($urandom); hif.mem_we = 1'($urandom);
      hif.mem_rd = 5'($urandom_range(0, 3)); hif.mem_result = $urandom;
      hif.id_valid = ($urandom_range(0, 4) != 0);
      hif.id_rs1 = 5'($urandom_range(0, 3)); hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.id_rs1_data = $urandom; hif.id_rs2_data = $urandom;
      cycle();
      checks++; if (hif.stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %0b want %0b", i, hif.stall, e_stall); end
      checks++; if (hif.rs1_out !== e_rs1) begin errors++; $display("FAIL rnd_rs1[%0d] got %h want %h", i, hif.rs1_out, e_rs1); end
      checks++; if (hif.rs2_out !== e_rs2) begin errors++; $display("FAIL rnd_rs2[%0d] got %h want %h", i, hif.rs2_out, e_rs2); end
      checks++; if (hif.bypass_flag !== e_flag) begin errors++; $display("FAIL rnd_flag[%0d] got %b want %b", i, hif.bypass_flag, e_flag); end
      checks++; if (hif.stall_count !== e_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, hif.stall_count, e_cnt); end
    end
    rst = 0;
  endtask

  initial begin
    m_rem = 0; m_cnt = 0;
    rst = 1; idle_inputs();
    test_reset();
    test_ex_fwd();
    test_priority();
    test_x0();
    test_id_invalid();
    test_load_use();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
